// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a BOOT/RUN/HALTED
// control FSM, with combinational decode of the latched instruction fields.
module fetch_stage #(
    parameter int unsigned IMEM_AW = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               halt,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic               fd_valid,
    output logic [31:0]        fd_pc,
    output logic [31:0]        fd_pc_plus1,
    output logic [31:0]        fd_insn,
    output logic [4:0]         fd_op,
    output logic [4:0]         fd_rd,
    output logic [4:0]         fd_rs,
    output logic [4:0]         fd_rt,
    output logic [31:0]        fd_imm,
    output logic [31:0]        fd_target,
    output logic [1:0]         state,
    output logic [31:0]        fetch_count
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_next;
    logic [31:0] pc_q, pc_next;
    logic        valid_q, valid_next;
    logic [31:0] fpc_q, fpc_next;
    logic [31:0] insn_q, insn_next;
    logic [31:0] count_q, count_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= '0;
            valid_q <= 1'b0;
            fpc_q   <= '0;
            insn_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_next;
            pc_q    <= pc_next;
            valid_q <= valid_next;
            fpc_q   <= fpc_next;
            insn_q  <= insn_next;
            count_q <= count_next;
        end
    end

    always_comb begin
        state_next = state_q;
        pc_next    = pc_q;
        valid_next = valid_q;
        fpc_next   = fpc_q;
        insn_next  = insn_q;
        count_next = count_q;
        case (state_q)
            BOOT: begin
                pc_next    = '0;
                state_next = halt ? HALTED : RUN;
            end
            RUN: begin
                // Priority: halt > redirect > flush > stall > normal fetch.
                if (halt) begin
                    state_next = HALTED;
                    valid_next = 1'b0;
                    fpc_next   = '0;
                    insn_next  = '0;
                end else if (redirect) begin
                    pc_next    = redirect_pc;
                    valid_next = 1'b0;
                    fpc_next   = '0;
                    insn_next  = '0;
                end else if (flush) begin
                    valid_next = 1'b0;
                    fpc_next   = '0;
                    insn_next  = '0;
                    if (!stall) pc_next = pc_q + 32'd1;
                end else if (!stall) begin
                    valid_next = 1'b1;
                    fpc_next   = pc_q;
                    insn_next  = imem_data;
                    pc_next    = pc_q + 32'd1;
                    count_next = count_q + 32'd1;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign imem_addr   = pc_q[IMEM_AW-1:0];
    assign fd_valid    = valid_q;
    assign fd_pc       = fpc_q;
    assign fd_pc_plus1 = fpc_q + 32'd1;
    assign fd_insn     = insn_q;
    assign fd_op       = insn_q[31:27];
    assign fd_rd       = insn_q[26:22];
    assign fd_rs       = insn_q[21:17];
    assign fd_rt       = insn_q[16:12];
    assign fd_imm      = {{15{insn_q[16]}}, insn_q[16:0]};
    assign fd_target   = {5'd0, insn_q[26:0]};
    assign state       = state_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with an asynchronous-read instruction memory model.
module tb_fetch_stage;

    localparam int unsigned AW = 12;

    logic          clock = 1'b0;
    logic          reset, stall, flush, redirect, halt;
    logic [31:0]   redirect_pc;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          fd_valid;
    logic [31:0]   fd_pc, fd_pc_plus1, fd_insn, fd_imm, fd_target, fetch_count;
    logic [4:0]    fd_op, fd_rd, fd_rs, fd_rt;
    logic [1:0]    state;

    logic [31:0] imem [0:(1<<AW)-1];
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign imem_data = imem[imem_addr];

    fetch_stage #(.IMEM_AW(AW)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .fd_valid(fd_valid), .fd_pc(fd_pc), .fd_pc_plus1(fd_pc_plus1),
        .fd_insn(fd_insn), .fd_op(fd_op), .fd_rd(fd_rd), .fd_rs(fd_rs),
        .fd_rt(fd_rt), .fd_imm(fd_imm), .fd_target(fd_target),
        .state(state), .fetch_count(fetch_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) imem[i] = 32'h0;
        imem[0]     = 32'h2800_0000;
        imem[1]     = 32'h3800_0000;
        imem[2]     = 32'h4000_0000;
        imem[3]     = 32'h4863_FFFF;
        imem[12'h100] = 32'h1000_0001;

        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        halt = 1'b0; redirect_pc = 32'h0;
        tick();
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_valid", {31'd0, fd_valid}, 32'd0);
        check("rst_pc", fd_pc, 32'd0);
        check("rst_pc_plus1", fd_pc_plus1, 32'd1);
        check("rst_insn", fd_insn, 32'd0);
        check("rst_imm", fd_imm, 32'd0);
        check("rst_target", fd_target, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_addr", {20'd0, imem_addr}, 32'd0);

        // BOOT cycle: no fetch
        reset = 1'b0;
        tick();
        check("boot_state", {30'd0, state}, 32'd1);
        check("boot_valid", {31'd0, fd_valid}, 32'd0);
        check("boot_addr", {20'd0, imem_addr}, 32'd0);

        tick();
        check("f0_op", {27'd0, fd_op}, 32'd5);
        check("f0_pc", fd_pc, 32'd0);
        check("f0_valid", {31'd0, fd_valid}, 32'd1);
        check("f0_count", fetch_count, 32'd1);
        tick();
        check("f1_op", {27'd0, fd_op}, 32'd7);
        check("f1_pc", fd_pc, 32'd1);
        check("f1_addr", {20'd0, imem_addr}, 32'd2);

        // two stall cycles while fd_pc=1
        stall = 1'b1;
        tick();
        tick();
        check("stall_pc", fd_pc, 32'd1);
        check("stall_addr", {20'd0, imem_addr}, 32'd2);
        check("stall_count", fetch_count, 32'd2);
        stall = 1'b0;
        tick();
        check("f2_op", {27'd0, fd_op}, 32'd8);
        check("f2_pc", fd_pc, 32'd2);
        check("f2_count", fetch_count, 32'd3);

        tick();
        check("dec_op", {27'd0, fd_op}, 32'd9);
        check("dec_rd", {27'd0, fd_rd}, 32'd1);
        check("dec_rs", {27'd0, fd_rs}, 32'd17);
        check("dec_rt", {27'd0, fd_rt}, 32'd31);
        check("dec_imm", fd_imm, 32'hFFFF_FFFF);
        check("dec_target", fd_target, 32'h0063_FFFF);
        check("dec_pc_plus1", fd_pc_plus1, 32'd4);
        check("dec_count", fetch_count, 32'd4);

        // flush alone
        flush = 1'b1;
        tick();
        check("flush_valid", {31'd0, fd_valid}, 32'd0);
        check("flush_op", {27'd0, fd_op}, 32'd0);
        check("flush_insn", fd_insn, 32'd0);
        check("flush_addr", {20'd0, imem_addr}, 32'd5);
        check("flush_count", fetch_count, 32'd4);
        flush = 1'b0;

        // redirect beats stall and flush
        redirect = 1'b1; redirect_pc = 32'h100; stall = 1'b1; flush = 1'b1;
        tick();
        check("redir_valid", {31'd0, fd_valid}, 32'd0);
        check("redir_addr", {20'd0, imem_addr}, 32'h100);
        check("redir_count", fetch_count, 32'd4);
        redirect = 1'b0; stall = 1'b0; flush = 1'b0;
        tick();
        check("redir_fpc", fd_pc, 32'h100);
        check("redir_op", {27'd0, fd_op}, 32'd2);
        check("redir_count2", fetch_count, 32'd5);

        // imem_addr wraps past the memory size while PC keeps counting
        redirect = 1'b1; redirect_pc = 32'hFFF;
        tick();
        check("wrapset_addr", {20'd0, imem_addr}, 32'hFFF);
        redirect = 1'b0;
        tick();
        check("wrap_fpc0", fd_pc, 32'hFFF);
        check("wrap_addr0", {20'd0, imem_addr}, 32'h000);
        tick();
        check("wrap_fpc1", fd_pc, 32'h1000);
        check("wrap_op1", {27'd0, fd_op}, 32'd5);
        check("wrap_addr1", {20'd0, imem_addr}, 32'h001);
        check("wrap_count", fetch_count, 32'd7);

        // flush with stall holds PC
        stall = 1'b1; flush = 1'b1;
        tick();
        check("fstall_valid", {31'd0, fd_valid}, 32'd0);
        check("fstall_addr", {20'd0, imem_addr}, 32'h001);
        check("fstall_count", fetch_count, 32'd7);
        stall = 1'b0; flush = 1'b0;

        // 32-bit PC wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        tick();
        check("pcwrap_fpc", fd_pc, 32'hFFFF_FFFF);
        check("pcwrap_plus1", fd_pc_plus1, 32'd0);
        check("pcwrap_addr", {20'd0, imem_addr}, 32'd0);
        check("pcwrap_count", fetch_count, 32'd8);

        // halt, then everything else ignored
        halt = 1'b1;
        tick();
        check("halt_state", {30'd0, state}, 32'd2);
        check("halt_valid", {31'd0, fd_valid}, 32'd0);
        check("halt_addr", {20'd0, imem_addr}, 32'd0);
        check("halt_count", fetch_count, 32'd8);
        halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        tick();
        check("halted_state", {30'd0, state}, 32'd2);
        check("halted_addr", {20'd0, imem_addr}, 32'd0);
        check("halted_count", fetch_count, 32'd8);

        // reset overrides a pending redirect in HALTED
        reset = 1'b1;
        tick();
        check("hrst_state", {30'd0, state}, 32'd0);
        check("hrst_addr", {20'd0, imem_addr}, 32'd0);
        check("hrst_count", fetch_count, 32'd0);
        check("hrst_plus1", fd_pc_plus1, 32'd1);
        redirect = 1'b0;

        // halt during BOOT goes straight to HALTED
        reset = 1'b0; halt = 1'b1;
        tick();
        check("boothalt_state", {30'd0, state}, 32'd2);
        check("boothalt_valid", {31'd0, fd_valid}, 32'd0);
        halt = 1'b0;
        tick();
        check("boothalt_hold", {30'd0, state}, 32'd2);

        // reset mid-stall after a fetch
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("pre_stall_count", fetch_count, 32'd1);
        stall = 1'b1; reset = 1'b1;
        tick();
        check("srst_state", {30'd0, state}, 32'd0);
        check("srst_count", fetch_count, 32'd0);
        check("srst_valid", {31'd0, fd_valid}, 32'd0);
        stall = 1'b0; reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
